// File: rtl/vga_pixel_unpacker_if.sv
// Read-side bus of the VGA pixel unpacker: FIFO pop port on one side,
// pixel stream towards the colour processor / timing generator on the other.
interface vga_pixel_unpacker_if #(
  parameter int unsigned DWIDTH = 32
);
  logic [DWIDTH-1:0] fifo_q;
  logic              fifo_empty;
  logic              fifo_rreq;
  logic [23:0]       pix_data;
  logic              pix_clut;
  logic              pix_valid;
  logic              pix_ready;

  modport master (
    input  fifo_q, fifo_empty, pix_ready,
    output fifo_rreq, pix_data, pix_clut, pix_valid
  );

  modport slave (
    output fifo_q, fifo_empty, pix_ready,
    input  fifo_rreq, pix_data, pix_clut, pix_valid
  );
endinterface

// File: rtl/vga_pixel_unpacker.sv
// Pops 32-bit big-endian words from the line FIFO into an 8-byte queue and
// emits one 24-bit pixel per transfer in 8/16/24/32 bpp modes.
module vga_pixel_unpacker #(
  parameter int unsigned DWIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            cmode,
  input  logic                  sof,
  vga_pixel_unpacker_if.master  bus
);

  typedef enum logic [1:0] {
    MODE_8BPP  = 2'b00,
    MODE_16BPP = 2'b01,
    MODE_24BPP = 2'b10,
    MODE_32BPP = 2'b11
  } mode_t;

  localparam logic [3:0] WORD_BYTES = 4'(DWIDTH / 8);

  mode_t       mode_q;
  logic [7:0]  q_r  [8];
  logic [7:0]  q_nx [8];
  logic [7:0]  wbyte [4];
  logic [3:0]  cnt_r;
  logic [3:0]  cnt_after;
  logic [3:0]  cnt_nx;
  logic [3:0]  bpp;
  logic        emit;
  logic        pop;
  logic [23:0] pix_nx;
  logic        clut_nx;
  logic [23:0] pix_data_r;
  logic        pix_clut_r;
  logic        pix_valid_r;

  always_comb begin
    bpp       = {2'b00, mode_q} + 4'd1;
    emit      = (cnt_r >= bpp) && (!pix_valid_r || bus.pix_ready);
    cnt_after = emit ? (cnt_r - bpp) : cnt_r;
    pop       = !bus.fifo_empty && (cnt_after <= 4'd4) && !rst && !sof;
    cnt_nx    = cnt_after + (pop ? WORD_BYTES : 4'd0);
  end

  assign bus.fifo_rreq = pop;

  always_comb begin
    for (int unsigned k = 0; k < 4; k++) begin
      wbyte[k] = bus.fifo_q[8*(3-k) +: 8];
    end
  end

  // Shift out the emitted bytes, then drop the popped word in right after
  // the surviving ones; both happen in the same cycle.
  always_comb begin
    logic [3:0] src;
    logic [3:0] rel;
    src = '0;
    rel = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      src     = 4'(i) + (emit ? bpp : 4'd0);
      q_nx[i] = (src < 4'd8) ? q_r[src[2:0]] : 8'h00;
      rel     = 4'(i) - cnt_after;
      if (pop && (4'(i) >= cnt_after) && (rel < WORD_BYTES)) begin
        q_nx[i] = wbyte[rel[1:0]];
      end
    end
  end

  always_comb begin
    pix_nx  = '0;
    clut_nx = 1'b0;
    case (mode_q)
      MODE_8BPP: begin
        pix_nx  = {16'h0000, q_r[0]};
        clut_nx = 1'b1;
      end
      MODE_16BPP: pix_nx = {q_r[0][7:3], 3'b000, q_r[0][2:0], q_r[1][7:5], 2'b00,
                            q_r[1][4:0], 3'b000};
      MODE_24BPP: pix_nx = {q_r[0], q_r[1], q_r[2]};
      MODE_32BPP: pix_nx = {q_r[1], q_r[2], q_r[3]};
      default:    pix_nx = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= mode_t'(cmode);
      cnt_r       <= '0;
      q_r         <= '{default: '0};
      pix_valid_r <= 1'b0;
      pix_data_r  <= '0;
      pix_clut_r  <= 1'b0;
    end else if (sof) begin
      mode_q      <= mode_t'(cmode);
      cnt_r       <= '0;
      pix_valid_r <= 1'b0;
    end else begin
      cnt_r <= cnt_nx;
      q_r   <= q_nx;
      if (emit) begin
        pix_valid_r <= 1'b1;
        pix_data_r  <= pix_nx;
        pix_clut_r  <= clut_nx;
      end else if (bus.pix_ready) begin
        pix_valid_r <= 1'b0;
      end
    end
  end

  assign bus.pix_data  = pix_data_r;
  assign bus.pix_clut  = pix_clut_r;
  assign bus.pix_valid = pix_valid_r;

endmodule

// File: tb/tb_vga_pixel_unpacker.sv
// Self-checking bench for vga_pixel_unpacker: directed scenarios plus a
// randomized stream compared against a byte-list pixel model.
module tb_vga_pixel_unpacker;

  logic       clk = 1'b0;
  logic       rst;
  logic       sof;
  logic [1:0] cmode;

  vga_pixel_unpacker_if #(.DWIDTH(32)) bus();

  vga_pixel_unpacker #(.DWIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .cmode (cmode),
    .sof   (sof),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_cmp;
  int          n_bad;
  int          n_pops;
  logic [31:0] fq [$];
  logic [24:0] got [$];
  logic        rreq_s;
  logic        acc_s;
  logic [24:0] pix_s;

  task automatic refresh();
    bus.fifo_empty = (fq.size() == 0);
    bus.fifo_q     = (fq.size() != 0) ? fq[0] : 32'hDEAD_BEEF;
  endtask

  task automatic push(input logic [31:0] w);
    fq.push_back(w);
    refresh();
  endtask

  // One clock: sample handshakes mid-cycle, then model the FIFO pop and the
  // consumer's acceptance at the rising edge.
  task automatic tick();
    @(negedge clk);
    rreq_s = bus.fifo_rreq;
    acc_s  = bus.pix_valid && bus.pix_ready && !rst && !sof;
    pix_s  = {bus.pix_clut, bus.pix_data};
    @(posedge clk);
    #1;
    if (rreq_s && fq.size() != 0) begin
      fq.delete(0);
      n_pops++;
    end
    refresh();
    if (acc_s) got.push_back(pix_s);
  endtask

  task automatic start_frame(input logic [1:0] m);
    cmode = m;
    sof   = 1'b1;
    tick();
    sof   = 1'b0;
    got.delete();
    n_pops = 0;
  endtask

  // Expected {clut, pixel} from the oldest four bytes of the stream.
  function automatic logic [24:0] fmt(input logic [1:0] m, input logic [7:0] b0,
                                      input logic [7:0] b1, input logic [7:0] b2,
                                      input logic [7:0] b3);
    logic [4:0] r5, bl5;
    logic [5:0] g6;
    r5  = b0[7:3];
    g6  = {b0[2:0], b1[7:5]};
    bl5 = b1[4:0];
    case (m)
      2'd0:    return {1'b1, 16'h0000, b0};
      2'd1:    return {1'b0, r5, 3'b000, g6, 2'b00, bl5, 3'b000};
      2'd2:    return {1'b0, b0, b1, b2};
      default: return {1'b0, b1, b2, b3};
    endcase
  endfunction

  task automatic test_reset();
    n_pops = 0;
    rst = 1'b1;
    cmode = 2'b01;
    bus.pix_ready = 1'b1;
    push(32'hF800_07E0);
    repeat (2) begin
      tick();
      n_cmp++;
      if (rreq_s !== 1'b0) begin
        n_bad++; $display("FAIL reset_rreq: got %b want 0", rreq_s);
      end
      n_cmp++;
      if ({bus.pix_valid, bus.pix_clut, bus.pix_data} !== 26'h0) begin
        n_bad++; $display("FAIL reset_outputs: got v=%b c=%b d=%h want 0/0/000000",
                          bus.pix_valid, bus.pix_clut, bus.pix_data);
      end
    end
    rst = 1'b0;
    cmode = 2'b11;
    tick();
    tick();
    n_cmp++;
    if ({bus.pix_valid, bus.pix_clut, bus.pix_data} !== {1'b1, 25'h0F80000}) begin
      n_bad++; $display("FAIL reset_mode_px0: got v=%b c=%b d=%h want 1/0/f80000",
                        bus.pix_valid, bus.pix_clut, bus.pix_data);
    end
    tick();
    n_cmp++;
    if ({bus.pix_valid, bus.pix_clut, bus.pix_data} !== {1'b1, 25'h000FC00}) begin
      n_bad++; $display("FAIL reset_mode_px1: got v=%b c=%b d=%h want 1/0/00fc00",
                        bus.pix_valid, bus.pix_clut, bus.pix_data);
    end
    tick();
    n_cmp++;
    if (bus.pix_valid !== 1'b0 || n_pops != 1) begin
      n_bad++; $display("FAIL reset_mode_end: got v=%b pops=%0d want 0/1", bus.pix_valid, n_pops);
    end
  endtask

  task automatic test_8bpp();
    logic [31:0] w;
    w = 32'h1122_3344;
    start_frame(2'b00);
    bus.pix_ready = 1'b1;
    push(w);
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++;
      if ({bus.pix_valid, bus.pix_clut, bus.pix_data} !== {2'b11, 16'h0, w[31-8*k -: 8]}) begin
        n_bad++; $display("FAIL 8bpp_px%0d: got v=%b c=%b d=%h want 1/1/0000%h", k,
                          bus.pix_valid, bus.pix_clut, bus.pix_data, w[31-8*k -: 8]);
      end
    end
    tick();
    n_cmp++;
    if (bus.pix_valid !== 1'b0 || n_pops != 1) begin
      n_bad++; $display("FAIL 8bpp_end: got v=%b pops=%0d want 0/1", bus.pix_valid, n_pops);
    end
  endtask

  task automatic test_16bpp();
    logic [24:0] exp_px [2];
    exp_px[0] = 25'h0F80000;
    exp_px[1] = 25'h000FC00;
    start_frame(2'b01);
    bus.pix_ready = 1'b1;
    push(32'hF800_07E0);
    tick();
    for (int k = 0; k < 2; k++) begin
      tick();
      n_cmp++;
      if ({bus.pix_valid, bus.pix_clut, bus.pix_data} !== {1'b1, exp_px[k]}) begin
        n_bad++; $display("FAIL 16bpp_px%0d: got v=%b cd=%h want 1/%h", k,
                          bus.pix_valid, {bus.pix_clut, bus.pix_data}, exp_px[k]);
      end
    end
    tick();
    n_cmp++;
    if (bus.pix_valid !== 1'b0) begin
      n_bad++; $display("FAIL 16bpp_end: got v=%b want 0", bus.pix_valid);
    end
  endtask

  task automatic test_24bpp();
    logic [23:0] exp_px [4];
    exp_px[0] = 24'hAABBCC;
    exp_px[1] = 24'h112233;
    exp_px[2] = 24'hDDEEFF;
    exp_px[3] = 24'h445566;
    start_frame(2'b10);
    bus.pix_ready = 1'b1;
    push(32'hAABB_CC11);
    push(32'h2233_DDEE);
    push(32'hFF44_5566);
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++;
      if ({bus.pix_valid, bus.pix_clut, bus.pix_data} !== {2'b10, exp_px[k]}) begin
        n_bad++; $display("FAIL 24bpp_px%0d: got v=%b c=%b d=%h want 1/0/%h", k,
                          bus.pix_valid, bus.pix_clut, bus.pix_data, exp_px[k]);
      end
    end
    tick();
    n_cmp++;
    if (bus.pix_valid !== 1'b0 || n_pops != 3) begin
      n_bad++; $display("FAIL 24bpp_end: got v=%b pops=%0d want 0/3", bus.pix_valid, n_pops);
    end
  endtask

  task automatic test_32bpp_backpressure();
    start_frame(2'b11);
    bus.pix_ready = 1'b1;
    push(32'h00A1_B2C3);
    push(32'h00D4_E5F6);
    tick();
    tick();
    bus.pix_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++;
      if ({bus.pix_valid, bus.pix_data} !== {1'b1, 24'hA1B2C3}) begin
        n_bad++; $display("FAIL 32bpp_stall%0d: got v=%b d=%h want 1/a1b2c3", k,
                          bus.pix_valid, bus.pix_data);
      end
    end
    bus.pix_ready = 1'b1;
    tick();
    n_cmp++;
    if ({bus.pix_valid, bus.pix_clut, bus.pix_data} !== {2'b10, 24'hD4E5F6}) begin
      n_bad++; $display("FAIL 32bpp_px1: got v=%b c=%b d=%h want 1/0/d4e5f6",
                        bus.pix_valid, bus.pix_clut, bus.pix_data);
    end
    tick();
    n_cmp++;
    if (got.size() != 2 || n_pops != 2) begin
      n_bad++; $display("FAIL 32bpp_count: got %0d px %0d pops want 2/2", got.size(), n_pops);
    end else begin
      n_cmp++;
      if (got[0] !== 25'h0A1B2C3 || got[1] !== 25'h0D4E5F6) begin
        n_bad++; $display("FAIL 32bpp_accepted: got %h %h want 0a1b2c3 0d4e5f6", got[0], got[1]);
      end
    end
  endtask

  task automatic test_sof_mid_word();
    start_frame(2'b10);
    bus.pix_ready = 1'b1;
    push(32'hAABB_CC11);
    tick();
    tick();
    n_cmp++;
    if ({bus.pix_valid, bus.pix_data} !== {1'b1, 24'hAABBCC}) begin
      n_bad++; $display("FAIL sof_first: got v=%b d=%h want 1/aabbcc", bus.pix_valid, bus.pix_data);
    end
    tick();
    cmode = 2'b11;
    sof = 1'b1;
    tick();
    sof = 1'b0;
    n_cmp++;
    if (bus.pix_valid !== 1'b0) begin
      n_bad++; $display("FAIL sof_valid: got %b want 0", bus.pix_valid);
    end
    push(32'h0012_3456);
    tick();
    tick();
    n_cmp++;
    if ({bus.pix_valid, bus.pix_clut, bus.pix_data} !== {2'b10, 24'h123456}) begin
      n_bad++; $display("FAIL sof_next_px: got v=%b c=%b d=%h want 1/0/123456",
                        bus.pix_valid, bus.pix_clut, bus.pix_data);
    end
    bus.pix_ready = 1'b0;
    tick();
    sof = 1'b1;
    tick();
    sof = 1'b0;
    n_cmp++;
    if (bus.pix_valid !== 1'b0) begin
      n_bad++; $display("FAIL sof_drop_pending: got v=%b want 0", bus.pix_valid);
    end
    bus.pix_ready = 1'b1;
  endtask

  task automatic test_reset_underrun();
    start_frame(2'b00);
    bus.pix_ready = 1'b1;
    push(32'h0102_0304);
    push(32'h0506_0708);
    push(32'h090A_0B0C);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    n_cmp++;
    if (rreq_s !== 1'b0 || {bus.pix_valid, bus.pix_clut, bus.pix_data} !== 26'h0) begin
      n_bad++; $display("FAIL rst_mid: got rreq=%b v=%b c=%b d=%h want 0/0/0/000000",
                        rreq_s, bus.pix_valid, bus.pix_clut, bus.pix_data);
    end
    rst = 1'b0;
    fq.delete();
    refresh();
    for (int k = 0; k < 6; k++) begin
      tick();
      n_cmp++;
      if (bus.pix_valid !== 1'b0) begin
        n_bad++; $display("FAIL underrun%0d: got v=%b want 0", k, bus.pix_valid);
      end
    end
  endtask

  task automatic test_random_stream();
    for (int m = 0; m < 4; m++) begin
      logic [7:0]  bytes [$];
      logic [7:0]  b [4];
      logic [31:0] w;
      logic [24:0] expv;
      int          bpp;
      int          nexp;
      int          pushed;
      int          guard;
      bpp = m + 1;
      pushed = 0;
      start_frame(m[1:0]);
      for (int c = 0; c < 400 && pushed < 16; c++) begin
        if ($urandom_range(0, 2) != 0) begin
          w = $urandom;
          push(w);
          for (int k = 0; k < 4; k++) bytes.push_back(w[31-8*k -: 8]);
          pushed++;
        end
        bus.pix_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 7) == 0) cmode = 2'($urandom_range(0, 3));
        tick();
      end
      bus.pix_ready = 1'b1;
      guard = 0;
      while ((fq.size() != 0 || bus.pix_valid) && guard < 500) begin
        tick();
        guard++;
      end
      repeat (4) tick();
      nexp = bytes.size() / bpp;
      n_cmp++;
      if (guard >= 500 || got.size() != nexp) begin
        n_bad++; $display("FAIL rand_m%0d_count: got %0d px (guard %0d) want %0d px",
                          m, got.size(), guard, nexp);
      end
      for (int p = 0; p < nexp && p < got.size(); p++) begin
        for (int k = 0; k < 4; k++) b[k] = (k < bpp) ? bytes[p*bpp + k] : 8'h00;
        expv = fmt(m[1:0], b[0], b[1], b[2], b[3]);
        n_cmp++;
        if (got[p] !== expv) begin
          n_bad++; $display("FAIL rand_m%0d_px%0d: got %h want %h", m, p, got[p], expv);
        end
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    n_pops = 0;
    rst = 1'b1;
    sof = 1'b0;
    cmode = 2'b00;
    bus.pix_ready = 1'b0;
    refresh();
    test_reset();
    test_8bpp();
    test_16bpp();
    test_24bpp();
    test_32bpp_backpressure();
    test_sof_mid_word();
    test_reset_underrun();
    test_random_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
